hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the five-stage processor. Sits in the decode stage directly upstream of the ID/EX control mux and drives its `holdControl` bubble input, plus the PC and pipeline-register write enables and flushes. Detects load-use hazards (multi-cycle bubble sequencing), taken branches resolved in EX (wrong-path flush), and data-memory wait (whole-pipeline freeze). Keeps a saturating stall-cycle counter for performance reporting.

## Interface
Parameters:
- `REG_ADDR_W`, 5: register-address width.
- `LOAD_BUBBLES`, 1: bubbles inserted per load-use hazard; legal range 1..3.
- `CNT_W`, 16: stall counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `idRs`, `idRt`  in  REG_ADDR_W  source registers of the instruction in ID.
- `idUsesRs`, `idUsesRt`  in  1  the ID instruction actually reads that source.
- `exMemRead`  in  1  instruction in EX is a load.
- `exRd`  in  REG_ADDR_W  destination of the EX instruction.
- `exBranchTaken`  in  1  branch in EX resolved taken this cycle.
- `memBusy`  in  1  data memory not ready; pipeline must freeze.
- `statClear`  in  1  synchronous clear of `stallCount`.
- `pcWrite`, `ifIdWrite`, `idExWrite`  out  1  register write enables.
- `holdControl`  out  1  to control mux: inject bubble into ID/EX.
- `ifIdFlush`, `idExFlush`  out  1  flush wrong-path instructions.
- `pipeFreeze`  out  1  hold EX/MEM and MEM/WB.
- `stallCount`  out  CNT_W  cycles with `pcWrite`=0, saturating.

## Operation
- `loadUse` (combinational) = `exMemRead` & (`exRd`≠0) & ((`idUsesRs` & `idRs`==`exRd`) | (`idUsesRt` & `idRt`==`exRd`)).
- FSM states: RUN, LOAD_STALL; 2-bit down-counter `remain`.
- Output priority, evaluated every cycle (highest first):
  1. `reset`=1: all enables 0, `holdControl`=1, flushes 0, `pipeFreeze`=1.
  2. `memBusy`=1: `pcWrite`=`ifIdWrite`=`idExWrite`=0, `pipeFreeze`=1, `holdControl`=0, flushes 0. State and `remain` hold.
  3. `exBranchTaken`=1: `pcWrite`=`ifIdWrite`=`idExWrite`=1, `ifIdFlush`=`idExFlush`=1, `holdControl`=1. Next state RUN, `remain`←0 (aborts any load stall; the dependent instruction is wrong-path).
  4. LOAD_STALL, or RUN with `loadUse`: `pcWrite`=`ifIdWrite`=0, `idExWrite`=1, `holdControl`=1, flushes 0, `pipeFreeze`=0.
  5. Otherwise: all write enables 1, `holdControl`=0, flushes 0, `pipeFreeze`=0.
- Transitions (only when not frozen):
  - RUN & `loadUse`: if LOAD_BUBBLES=1 stay RUN; else →LOAD_STALL, `remain`←LOAD_BUBBLES−1.
  - LOAD_STALL: `remain`←`remain`−1; when `remain`=1 →RUN.
- In RUN after a stall, `loadUse` is re-evaluated normally. The bubble has cleared `exMemRead`, so the same hazard does not re-trigger.
- `stallCount`: +1 on each clock edge with `reset`=0 and `pcWrite`=0; saturates at 2^CNT_W−1. `statClear` sets it to 0 and overrides the increment that cycle.

## Timing
- Reset values: state=RUN, `remain`=0, `stallCount`=0. Combinational outputs follow priority 1 while `reset` is asserted.
- Detection-to-output latency is 0 cycles: outputs are Mealy in RUN and Moore in LOAD_STALL.
- A load-use hazard costs exactly LOAD_BUBBLES cycles of `pcWrite`=0, excluding freeze cycles.
- A freeze during LOAD_STALL extends the stall by the freeze length; no bubble is lost.
- A branch held in EX during a freeze flushes on the first cycle with `memBusy`=0.
- Asserting `reset` mid-stall returns the block to RUN immediately. Counter contents are discarded.

## Test plan
- LOAD_BUBBLES=1; `exMemRead`=1, `exRd`=3, `idRs`=3, `idUsesRs`=1 for one cycle -> `holdControl`=1 and `pcWrite`=0 for exactly 1 cycle; `stallCount`=1.
- LOAD_BUBBLES=3; same hazard -> 3 consecutive bubble cycles, then RUN; `stallCount`=3.
- `exRd`=0 matching `idRs`=0, or `idUsesRt`=0 with `idRt`==`exRd` -> no stall; all enables 1.
- LOAD_BUBBLES=3; hazard, then `exBranchTaken`=1 on the 2nd bubble cycle -> that cycle shows both flushes=1 and `pcWrite`=1; next cycle is RUN with no further bubble.
- `memBusy`=1 for 4 cycles during LOAD_STALL (LOAD_BUBBLES=2) -> `pipeFreeze`=1 and `holdControl`=0 for those 4 cycles; the remaining bubble follows; `stallCount`=6.
- Preload `stallCount`=0xFFFE, stall 3 cycles -> counter holds at 0xFFFF. Then `statClear`=1 during a stall cycle -> 0.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use bubble sequencing, taken-branch flush,
// data-memory freeze, and a saturating stall-cycle counter.
module hazard_unit #(
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] idRs,
  input  logic [REG_ADDR_W-1:0] idRt,
  input  logic                  idUsesRs,
  input  logic                  idUsesRt,
  input  logic                  exMemRead,
  input  logic [REG_ADDR_W-1:0] exRd,
  input  logic                  exBranchTaken,
  input  logic                  memBusy,
  input  logic                  statClear,
  output logic                  pcWrite,
  output logic                  ifIdWrite,
  output logic                  idExWrite,
  output logic                  holdControl,
  output logic                  ifIdFlush,
  output logic                  idExFlush,
  output logic                  pipeFreeze,
  output logic [CNT_W-1:0]      stallCount
);

  typedef enum logic {
    RUN,
    LOAD_STALL
  } state_e;

  // Bubbles still owed after the hazard cycle itself.
  localparam logic [1:0] REMAIN_INIT  = 2'(LOAD_BUBBLES - 1);
  localparam bit         MULTI_BUBBLE = (LOAD_BUBBLES > 1);

  state_e           state_q, state_d;
  logic [1:0]       remain_q, remain_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             load_use;

  assign load_use = exMemRead && (exRd != '0) &&
                    ((idUsesRs && (idRs == exRd)) || (idUsesRt && (idRt == exRd)));

  // NOTE: every output and next-state signal gets a default before the
  // priority chain, so no path through this block can infer a latch.
  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    pcWrite     = 1'b1;
    ifIdWrite   = 1'b1;
    idExWrite   = 1'b1;
    holdControl = 1'b0;
    ifIdFlush   = 1'b0;
    idExFlush   = 1'b0;
    pipeFreeze  = 1'b0;

    if (reset) begin
      pcWrite     = 1'b0;
      ifIdWrite   = 1'b0;
      idExWrite   = 1'b0;
      holdControl = 1'b1;
      pipeFreeze  = 1'b1;
    end else if (memBusy) begin
      // Freeze: state and remaining bubble count are held untouched.
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      idExWrite  = 1'b0;
      pipeFreeze = 1'b1;
    end else if (exBranchTaken) begin
      ifIdFlush   = 1'b1;
      idExFlush   = 1'b1;
      holdControl = 1'b1;
      state_d     = RUN;
      remain_d    = 2'd0;
    end else if ((state_q == LOAD_STALL) || load_use) begin
      pcWrite     = 1'b0;
      ifIdWrite   = 1'b0;
      holdControl = 1'b1;
      if (state_q == RUN) begin
        if (MULTI_BUBBLE) begin
          state_d  = LOAD_STALL;
          remain_d = REMAIN_INIT;
        end
      end else begin
        remain_d = remain_q - 2'd1;
        if (remain_q <= 2'd1) begin
          state_d = RUN;
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (statClear) begin
      count_d = '0;
    end else if (!pcWrite && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      remain_q <= 2'd0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      count_q  <= count_d;
    end
  end

  assign stallCount = count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: three instances (1, 2 and 3 load bubbles)
// share one stimulus stream; each scenario checks the instance it targets.
module tb_hazard_unit;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic hold_control;
    logic if_id_flush;
    logic id_ex_flush;
    logic pipe_freeze;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, ex_mem_read, ex_branch_taken, mem_busy, stat_clear;

  ctl_t        o1, o2, o3;
  logic [15:0] cnt1, cnt2;
  logic [3:0]  cnt3;

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  hazard_unit #(.REG_ADDR_W(5), .LOAD_BUBBLES(1), .CNT_W(16)) u_lb1 (
    .clk(clk), .reset(reset), .idRs(id_rs), .idRt(id_rt),
    .idUsesRs(id_uses_rs), .idUsesRt(id_uses_rt), .exMemRead(ex_mem_read),
    .exRd(ex_rd), .exBranchTaken(ex_branch_taken), .memBusy(mem_busy),
    .statClear(stat_clear), .pcWrite(o1.pc_write), .ifIdWrite(o1.if_id_write),
    .idExWrite(o1.id_ex_write), .holdControl(o1.hold_control),
    .ifIdFlush(o1.if_id_flush), .idExFlush(o1.id_ex_flush),
    .pipeFreeze(o1.pipe_freeze), .stallCount(cnt1)
  );

  hazard_unit #(.REG_ADDR_W(5), .LOAD_BUBBLES(2), .CNT_W(16)) u_lb2 (
    .clk(clk), .reset(reset), .idRs(id_rs), .idRt(id_rt),
    .idUsesRs(id_uses_rs), .idUsesRt(id_uses_rt), .exMemRead(ex_mem_read),
    .exRd(ex_rd), .exBranchTaken(ex_branch_taken), .memBusy(mem_busy),
    .statClear(stat_clear), .pcWrite(o2.pc_write), .ifIdWrite(o2.if_id_write),
    .idExWrite(o2.id_ex_write), .holdControl(o2.hold_control),
    .ifIdFlush(o2.if_id_flush), .idExFlush(o2.id_ex_flush),
    .pipeFreeze(o2.pipe_freeze), .stallCount(cnt2)
  );

  // Narrow counter so saturation is reachable in a few cycles.
  hazard_unit #(.REG_ADDR_W(5), .LOAD_BUBBLES(3), .CNT_W(4)) u_lb3 (
    .clk(clk), .reset(reset), .idRs(id_rs), .idRt(id_rt),
    .idUsesRs(id_uses_rs), .idUsesRt(id_uses_rt), .exMemRead(ex_mem_read),
    .exRd(ex_rd), .exBranchTaken(ex_branch_taken), .memBusy(mem_busy),
    .statClear(stat_clear), .pcWrite(o3.pc_write), .ifIdWrite(o3.if_id_write),
    .idExWrite(o3.id_ex_write), .holdControl(o3.hold_control),
    .ifIdFlush(o3.if_id_flush), .idExFlush(o3.id_ex_flush),
    .pipeFreeze(o3.pipe_freeze), .stallCount(cnt3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packed control word order: pc, ifId, idEx, hold, ifIdFlush, idExFlush, freeze.
  localparam ctl_t RST_CTL    = 7'b000_1_00_1;
  localparam ctl_t RUN_CTL    = 7'b111_0_00_0;
  localparam ctl_t BUBBLE_CTL = 7'b001_1_00_0;
  localparam ctl_t FREEZE_CTL = 7'b000_0_00_1;
  localparam ctl_t BRANCH_CTL = 7'b111_1_11_0;

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; mem_busy = 1'b0; stat_clear = 1'b0;
  endtask

  task automatic hazard();
    ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs = 5'd3; id_uses_rs = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick(); idle(); reset = 1'b1;
    tick(); reset = 1'b0; #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    reset = 1'b1;
    #2;
    check("reset_ctl", 32'(o1), 32'(RST_CTL));
    check("reset_cnt", 32'(cnt1), 32'd0);
    tick(); reset = 1'b0; #1;
    check("run_ctl", 32'(o1), 32'(RUN_CTL));

    // One-bubble load-use.
    tick(); hazard(); #1;
    check("lb1_bubble", 32'(o1), 32'(BUBBLE_CTL));
    tick(); idle(); #1;
    check("lb1_after", 32'(o1), 32'(RUN_CTL));
    check("lb1_cnt", 32'(cnt1), 32'd1);

    // Non-hazards: rd=0, and an unused rt matching rd.
    tick(); ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1; #1;
    check("rd_zero", 32'(o1), 32'(RUN_CTL));
    tick(); idle(); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rt = 5'd5;
    id_rs = 5'd2; id_uses_rs = 1'b1; #1;
    check("rt_unused", 32'(o3), 32'(RUN_CTL));
    id_uses_rt = 1'b1; #1;
    check("rt_used", 32'(o1), 32'(BUBBLE_CTL));

    // Three-bubble load-use.
    do_reset();
    tick(); hazard(); #1;
    check("lb3_b1", 32'(o3), 32'(BUBBLE_CTL));
    tick(); idle(); #1;
    check("lb3_b2", 32'(o3), 32'(BUBBLE_CTL));
    tick(); #1;
    check("lb3_b3", 32'(o3), 32'(BUBBLE_CTL));
    tick(); #1;
    check("lb3_run", 32'(o3), 32'(RUN_CTL));
    check("lb3_cnt", 32'(cnt3), 32'd3);

    // Branch aborts a stall on the second bubble.
    do_reset();
    tick(); hazard(); #1;
    check("br_b1", 32'(o3), 32'(BUBBLE_CTL));
    tick(); idle(); ex_branch_taken = 1'b1; #1;
    check("br_flush", 32'(o3), 32'(BRANCH_CTL));
    tick(); idle(); #1;
    check("br_run", 32'(o3), 32'(RUN_CTL));
    check("br_cnt", 32'(cnt3), 32'd1);

    // Freeze inside a two-bubble stall.
    do_reset();
    tick(); hazard(); #1;
    check("fz_b1", 32'(o2), 32'(BUBBLE_CTL));
    for (int i = 0; i < 4; i++) begin
      tick(); idle(); mem_busy = 1'b1; #1;
      check("fz_hold", 32'(o2), 32'(FREEZE_CTL));
    end
    tick(); idle(); #1;
    check("fz_b2", 32'(o2), 32'(BUBBLE_CTL));
    tick(); #1;
    check("fz_run", 32'(o2), 32'(RUN_CTL));
    check("fz_cnt", 32'(cnt2), 32'd6);

    // Branch held in EX across a freeze.
    do_reset();
    tick(); mem_busy = 1'b1; ex_branch_taken = 1'b1; #1;
    check("brfz_hold", 32'(o1), 32'(FREEZE_CTL));
    tick(); mem_busy = 1'b0; #1;
    check("brfz_flush", 32'(o1), 32'(BRANCH_CTL));

    // Reset mid-stall.
    do_reset();
    tick(); hazard(); #1;
    tick(); idle(); #1;
    check("rs_stall", 32'(o3), 32'(BUBBLE_CTL));
    reset = 1'b1; #1;
    check("rs_ctl", 32'(o3), 32'(RST_CTL));
    check("rs_cnt", 32'(cnt3), 32'd0);
    tick(); reset = 1'b0; #1;
    check("rs_run", 32'(o3), 32'(RUN_CTL));

    // Saturation of the 4-bit counter, then clear during a stall.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      tick(); mem_busy = 1'b1;
    end
    tick(); idle(); #1;
    check("sat_pre", 32'(cnt3), 32'hE);
    tick(); hazard(); #1;
    tick(); idle(); #1;
    check("sat_max", 32'(cnt3), 32'hF);
    tick(); #1;
    tick(); #1;
    check("sat_hold", 32'(cnt3), 32'hF);
    check("sat_run", 32'(o3), 32'(RUN_CTL));
    tick(); hazard(); stat_clear = 1'b1; #1;
    tick(); idle(); #1;
    check("clr_cnt", 32'(cnt3), 32'd0);
    check("clr_stall", 32'(o3), 32'(BUBBLE_CTL));

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
